mem_bus_arbiter: RTL and testbench

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

---
 rtl/mem_bus_arb_pkg.sv | 16 +
 rtl/mem_bus_arb_prio.sv | 30 +++
 rtl/mem_bus_arbiter.sv | 115 +++++++++++
 tb/tb_mem_bus_arbiter.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_arb_pkg.sv
// Shared definitions for the three-master memory bus arbiter.
package mem_bus_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   localparam int M_DBG = 0;
   localparam int M_LSU = 1;
   localparam int M_IFU = 2;

   localparam int STARVE_LIMIT_DEF = 4;

endpackage

// File: rtl/mem_bus_arb_prio.sv
// Combinational three-way picker: debug loader first, then core data ahead of
// ifetch unless the ifetch port is starving, in which case ifetch moves up.
module mem_bus_arb_prio
   import mem_bus_arb_pkg::*;
(
   input  logic [2:0] req,
   input  logic       starve,
   output logic [2:0] win_oh,
   output logic [1:0] win_idx
);

   always_comb begin
      win_oh  = 3'b000;
      win_idx = 2'd0;
      if (req[M_DBG]) begin
         win_oh  = 3'b001;
         win_idx = 2'(M_DBG);
      end else if (starve && req[M_IFU]) begin
         win_oh  = 3'b100;
         win_idx = 2'(M_IFU);
      end else if (req[M_LSU]) begin
         win_oh  = 3'b010;
         win_idx = 2'(M_LSU);
      end else if (req[M_IFU]) begin
         win_oh  = 3'b100;
         win_idx = 2'(M_IFU);
      end
   end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Single-outstanding memory bus arbiter for debug loader, core data and core
// ifetch, with starvation promotion of the ifetch port over core data.
module mem_bus_arbiter
   import mem_bus_arb_pkg::*;
#(
   parameter int AW           = 32,
   parameter int DW           = 32,
   parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [2:0]      m_req,
   input  logic [3*AW-1:0] m_addr,
   input  logic [2:0]      m_we,
   input  logic [3*DW-1:0] m_wdata,
   output logic [2:0]      m_gnt,
   output logic [2:0]      m_rvalid,
   output logic [DW-1:0]   m_rdata,
   output logic            s_req,
   output logic [AW-1:0]   s_addr,
   output logic            s_we,
   output logic [DW-1:0]   s_wdata,
   input  logic            s_ready,
   input  logic            s_rvalid,
   input  logic [DW-1:0]   s_rdata,
   output logic            hold_o
);

   localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

   state_e     state_q, state_d;
   logic [1:0] owner_q, owner_d;
   logic [2:0] starve_q, starve_d;

   logic [2:0] owner_oh;
   logic [2:0] arb_req;
   logic [2:0] win_oh;
   logic [1:0] win_idx;
   logic       arb_take;

   assign owner_oh = 3'b001 << owner_q;

   // The current owner's request was already consumed by its grant, so it is
   // masked out when re-arbitrating on the response cycle.
   assign arb_req  = (state_q == ST_IDLE) ? m_req : (m_req & ~owner_oh);
   assign arb_take = ((state_q == ST_IDLE) && (|m_req)) ||
                     ((state_q == ST_RESP) && s_rvalid && (|arb_req));

   mem_bus_arb_prio u_prio (
      .req     (arb_req),
      .starve  (starve_q == LIMIT),
      .win_oh  (win_oh),
      .win_idx (win_idx)
   );

   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      starve_d = starve_q;
      s_req    = 1'b0;
      s_addr   = '0;
      s_we     = 1'b0;
      s_wdata  = '0;
      m_gnt    = 3'b000;
      m_rvalid = 3'b000;
      m_rdata  = '0;

      case (state_q)
         ST_IDLE: begin
            if (|m_req) state_d = ST_ADDR;
         end
         ST_ADDR: begin
            s_req   = 1'b1;
            s_addr  = m_addr[int'(owner_q)*AW +: AW];
            s_we    = m_we[owner_q];
            s_wdata = m_wdata[int'(owner_q)*DW +: DW];
            if (s_ready) begin
               m_gnt   = owner_oh;
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            if (s_rvalid) begin
               m_rvalid = owner_oh;
               m_rdata  = s_rdata;
               state_d  = (|arb_req) ? ST_ADDR : ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (arb_take) begin
         owner_d = win_idx;
         if (arb_req[M_IFU] && !win_oh[M_IFU])
            starve_d = (starve_q == LIMIT) ? starve_q : starve_q + 3'd1;
         else
            starve_d = 3'd0;
      end
   end

   assign hold_o = (m_req[M_LSU] | m_req[M_IFU]) & ~(m_gnt[M_LSU] | m_gnt[M_IFU]);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         owner_q  <= 2'd0;
         starve_q <= 3'd0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         starve_q <= starve_d;
      end
   end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed and randomized bench for mem_bus_arbiter against a cycle model.
module tb_mem_bus_arbiter;

   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int LIM = 4;

   logic            clk = 1'b0;
   logic            rst;
   logic [2:0]      m_req;
   logic [3*AW-1:0] m_addr;
   logic [2:0]      m_we;
   logic [3*DW-1:0] m_wdata;
   logic [2:0]      m_gnt;
   logic [2:0]      m_rvalid;
   logic [DW-1:0]   m_rdata;
   logic            s_req;
   logic [AW-1:0]   s_addr;
   logic            s_we;
   logic [DW-1:0]   s_wdata;
   logic            s_ready;
   logic            s_rvalid;
   logic [DW-1:0]   s_rdata;
   logic            hold_o;

   int tests = 0;
   int fails = 0;

   // Model: phase 0 idle, 1 address, 2 response
   int ph  = 0;
   int own = 0;
   int cnt = 0;

   mem_bus_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(LIM)) dut (
      .clk(clk), .rst(rst), .m_req(m_req), .m_addr(m_addr), .m_we(m_we),
      .m_wdata(m_wdata), .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
      .s_req(s_req), .s_addr(s_addr), .s_we(s_we), .s_wdata(s_wdata),
      .s_ready(s_ready), .s_rvalid(s_rvalid), .s_rdata(s_rdata), .hold_o(hold_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int pick(input logic [2:0] r, input int c);
      int ord[3];
      if (c == LIM) ord = '{0, 2, 1};
      else          ord = '{0, 1, 2};
      foreach (ord[i]) if (r[ord[i]]) return ord[i];
      return -1;
   endfunction

   task automatic arbitrate(input logic [2:0] r);
      int w;
      w   = pick(r, cnt);
      own = w;
      if (r[2] && w != 2) cnt = (cnt < LIM) ? cnt + 1 : LIM;
      else                cnt = 0;
   endtask

   task automatic model_reset();
      ph  = 0;
      own = 0;
      cnt = 0;
   endtask

   task automatic model_update();
      logic [2:0] r;
      case (ph)
         0: if (m_req != 3'b000) begin arbitrate(m_req); ph = 1; end
         1: if (s_ready) ph = 2;
         default: if (s_rvalid) begin
            r = m_req & ~(3'b001 << own);
            if (r != 3'b000) begin arbitrate(r); ph = 1; end
            else ph = 0;
         end
      endcase
   endtask

   task automatic check_outputs();
      logic [2:0] eg, ev;
      logic       eh;
      eg = (ph == 1 && s_ready)  ? (3'b001 << own) : 3'b000;
      ev = (ph == 2 && s_rvalid) ? (3'b001 << own) : 3'b000;
      eh = (m_req[1] | m_req[2]) & ~(eg[1] | eg[2]);
      chk("s_req", 64'(s_req), 64'(ph == 1));
      chk("m_gnt", 64'(m_gnt), 64'(eg));
      chk("m_rvalid", 64'(m_rvalid), 64'(ev));
      chk("hold_o", 64'(hold_o), 64'(eh));
      if (ph == 1) begin
         chk("s_addr", 64'(s_addr), 64'(m_addr[own*AW +: AW]));
         chk("s_we", 64'(s_we), 64'(m_we[own]));
         chk("s_wdata", 64'(s_wdata), 64'(m_wdata[own*DW +: DW]));
      end
      if (ev != 3'b000) chk("m_rdata", 64'(m_rdata), 64'(s_rdata));
   endtask

   task automatic settle();
      @(negedge clk);
      check_outputs();
   endtask

   task automatic advance();
      @(posedge clk);
      if (rst) model_reset();
      else     model_update();
      #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_s_req"}, 64'(s_req), 64'd0);
      chk({tag, "_s_we"}, 64'(s_we), 64'd0);
      chk({tag, "_s_addr"}, 64'(s_addr), 64'd0);
      chk({tag, "_s_wdata"}, 64'(s_wdata), 64'd0);
      chk({tag, "_m_gnt"}, 64'(m_gnt), 64'd0);
      chk({tag, "_m_rvalid"}, 64'(m_rvalid), 64'd0);
      chk({tag, "_m_rdata"}, 64'(m_rdata), 64'd0);
   endtask

   initial begin
      logic [2:0] exp_g [6];
      rst = 1'b1; m_req = '0; m_addr = '0; m_we = '0; m_wdata = '0;
      s_ready = 1'b0; s_rvalid = 1'b0; s_rdata = '0;
      model_reset();
      #2;
      chk_all_zero("reset");
      @(posedge clk); #1;
      rst = 1'b0;

      // Single read from core data
      m_req = 3'b010; m_addr[1*AW +: AW] = 32'h100; s_ready = 1'b1;
      settle(); chk("read_gnt_c0", 64'(m_gnt), 64'd0); advance();
      settle(); chk("read_gnt_c1", 64'(m_gnt), 64'h2); advance();
      m_req = 3'b000; s_rvalid = 1'b1; s_rdata = 32'hDEADBEEF;
      settle(); chk("read_rvalid", 64'(m_rvalid), 64'h2);
      chk("read_rdata", 64'(m_rdata), 64'hDEADBEEF); advance();
      s_rvalid = 1'b0;

      // Write from debug loader
      m_req = 3'b001; m_we = 3'b001; m_addr[0 +: AW] = 32'h20; m_wdata[0 +: DW] = 32'h5A5A5A5A;
      settle(); advance();
      settle(); chk("wr_s_we", 64'(s_we), 64'd1);
      chk("wr_s_wdata", 64'(s_wdata), 64'h5A5A5A5A);
      chk("wr_s_addr", 64'(s_addr), 64'h20); advance();
      m_req = 3'b000; m_we = 3'b000; s_rvalid = 1'b1;
      settle(); chk("wr_rvalid", 64'(m_rvalid), 64'h1); advance();
      s_rvalid = 1'b0;

      // Slave stall for three address cycles
      m_req = 3'b010; m_addr[1*AW +: AW] = 32'h40; s_ready = 1'b0;
      settle(); advance();
      for (int i = 0; i < 3; i++) begin
         settle();
         chk("stall_s_req", 64'(s_req), 64'd1);
         chk("stall_s_addr", 64'(s_addr), 64'h40);
         chk("stall_hold", 64'(hold_o), 64'd1);
         advance();
      end
      s_ready = 1'b1;
      settle(); chk("stall_gnt", 64'(m_gnt), 64'h2);
      chk("stall_hold_rel", 64'(hold_o), 64'd0); advance();
      m_req = 3'b000; s_rvalid = 1'b1;
      settle(); advance();
      s_rvalid = 1'b0;

      // Starvation promotion of ifetch
      exp_g = '{3'b001, 3'b010, 3'b010, 3'b010, 3'b100, 3'b010};
      for (int r = 0; r < 6; r++) begin
         m_req = (r == 0) ? 3'b111 : 3'b110;
         settle(); advance();
         settle(); chk($sformatf("starve_gnt%0d", r), 64'(m_gnt), 64'(exp_g[r])); advance();
         m_req = 3'b000; s_rvalid = 1'b1;
         settle(); advance();
         s_rvalid = 1'b0;
      end

      // Back-to-back core data and ifetch
      m_req = 3'b110; s_ready = 1'b1; s_rvalid = 1'b1;
      for (int k = 0; k < 10; k++) begin
         settle();
         if (k % 2 == 0)      chk("b2b_gap", 64'(m_gnt), 64'd0);
         else if (k % 4 == 1) chk("b2b_gnt", 64'(m_gnt), 64'h2);
         else                 chk("b2b_gnt", 64'(m_gnt), 64'h4);
         if (k > 0)           chk("b2b_busy", 64'(ph == 0), 64'd0);
         advance();
      end
      m_req = 3'b000;
      while (ph != 0) begin settle(); advance(); end
      s_rvalid = 1'b0;

      // Reset in the middle of a response
      m_req = 3'b010;
      settle(); advance();
      settle(); advance();
      m_req = 3'b000;
      rst = 1'b1; s_rvalid = 1'b1; s_rdata = 32'h12345678;
      #1;
      model_reset();
      chk_all_zero("rst_mid");
      advance(); advance();
      rst = 1'b0;
      settle(); chk("post_rst_rvalid", 64'(m_rvalid), 64'd0);
      chk("post_rst_s_req", 64'(s_req), 64'd0); advance();
      s_rvalid = 1'b0;

      // Randomized traffic
      for (int c = 0; c < 3000; c++) begin
         m_req    = ($urandom_range(0, 3) == 0) ? 3'b000 : 3'($urandom_range(0, 7));
         m_addr   = {$urandom, $urandom, $urandom};
         m_wdata  = {$urandom, $urandom, $urandom};
         m_we     = 3'($urandom_range(0, 7));
         s_ready  = ($urandom_range(0, 3) != 0);
         s_rvalid = ($urandom_range(0, 1) != 0);
         s_rdata  = $urandom;
         settle(); advance();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
